// File: rtl/instr_fetch_sequencer.sv
// rtl/instr_fetch_sequencer.sv - fetch/decode/execute sequencer for the 10-bit CPU (optional SINGLE_STEP_EN)
module instr_fetch_sequencer #(
  parameter int ADDR_W      = 4,
  parameter int IR_W        = 10,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
`ifdef SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [IR_W-1:0]   mem_rdata,
  output logic [IR_W-1:0]   IR,
  output logic              IRload,
  input  logic              J_EN,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        state,
  output logic              halted,
  output logic              fault
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(ACK_TIMEOUT);

  state_t           st;
  logic [CNT_W-1:0] wait_cnt;
  logic             go;
  logic             continue_run;

  assign state    = st;
  assign mem_addr = pc;

`ifdef SINGLE_STEP_EN
  logic step_q;

  // Remember last step level so a held step yields only one start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step;
  end

  // Start only on a fresh step edge; every instruction returns to IDLE
  assign go           = run & step & ~step_q;
  assign continue_run = 1'b0;
`else
  assign go           = run;
  assign continue_run = run;
`endif

  // Main sequencer: state, PC, IR and all registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_IDLE;
      pc       <= '0;
      IR       <= '0;
      mem_req  <= 1'b0;
      IRload   <= 1'b0;
      halted   <= 1'b0;
      fault    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          mem_req <= 1'b0;
          if (go) begin
            st       <= S_FETCH;
            mem_req  <= 1'b1;
            wait_cnt <= '0;
          end
        end
        S_FETCH: begin
          if (mem_ack) begin
            IR      <= mem_rdata;
            mem_req <= 1'b0;
            IRload  <= 1'b1;
            st      <= S_DECODE;
          end else if ((ACK_TIMEOUT != 0) && (wait_cnt + CNT_W'(1) == TIMEOUT_LIMIT)) begin
            // Memory never answered: park the core until reset
            mem_req <= 1'b0;
            fault   <= 1'b1;
            halted  <= 1'b1;
            st      <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_DECODE: begin
          IRload <= 1'b0;
          if (IR[IR_W-1 -: 4] == 4'b0000) begin
            // HALT leaves pc pointing at the HALT word
            halted <= 1'b1;
            st     <= S_HALT;
          end else begin
            st <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (J_EN) pc <= ADDR_W'(IR[3:0]);
          else      pc <= pc + ADDR_W'(1);
          if (continue_run) begin
            st       <= S_FETCH;
            mem_req  <= 1'b1;
            wait_cnt <= '0;
          end else begin
            st <= S_IDLE;
          end
        end
        S_HALT, S_FAULT: begin
          mem_req <= 1'b0;
        end
        default: begin
          st      <= S_IDLE;
          mem_req <= 1'b0;
          IRload  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// tb/tb_instr_fetch_sequencer.sv - directed self-checking bench for instr_fetch_sequencer
module tb_instr_fetch_sequencer;

  localparam logic [9:0] OP_ADD = 10'b0001_000001;
  localparam logic [9:0] OP_SUB = 10'b0010_000010;
  localparam logic [9:0] OP_HLT = 10'b0000_000000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       mem_req, mem_ack, IRload, J_EN, halted, fault;
  logic [3:0] mem_addr, pc;
  logic [9:0] mem_rdata, IR;
  logic [2:0] state;
`ifdef SINGLE_STEP_EN
  logic       step = 1'b0;
`endif

  logic [9:0] mem [16];
  logic       ack_en = 1'b1;
  int         errors = 0;
  int         checks = 0;
  int         fetch_q[$];
  int         load_q[$];

  instr_fetch_sequencer #(.ADDR_W(4), .IR_W(10), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .IR(IR), .IRload(IRload), .J_EN(J_EN), .pc(pc), .state(state),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  // Zero-wait memory and a decoder that jumps on opcode 0101
  assign mem_ack   = ack_en & mem_req;
  assign mem_rdata = mem[mem_addr];
  assign J_EN      = (state == 3'd3) && (IR[9:6] == 4'b0101);

  // Log fetch addresses and the pc seen on each IRload pulse
  always @(negedge clk) begin
    if (mem_req && mem_ack) fetch_q.push_back(int'(mem_addr));
    if (IRload) load_q.push_back(int'(pc));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_mem(input logic [9:0] w);
    for (int i = 0; i < 16; i++) mem[i] = w;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    run    = 1'b0;
    ack_en = 1'b1;
    repeat (2) @(negedge clk);
    fetch_q.delete();
    load_q.delete();
    rst_n = 1'b1;
  endtask

  int cyc;
  int cnt;
  int exp_fetch[7] = '{0, 1, 2, 3, 10, 15, 0};

  initial begin
    fill_mem(OP_ADD);
    repeat (2) @(negedge clk);
    check("rst_state",   32'(state),   32'd0);
    check("rst_pc",      32'(pc),      32'd0);
    check("rst_ir",      32'(IR),      32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_irload",  32'(IRload),  32'd0);
    check("rst_halted",  32'(halted),  32'd0);
    check("rst_fault",   32'(fault),   32'd0);

    // ADD, SUB, HALT at 3 cycles per instruction
    do_reset();
    fill_mem(OP_ADD);
    mem[0] = OP_ADD; mem[1] = OP_SUB; mem[2] = OP_HLT;
    run = 1'b1;
    cyc = 0;
    while (!halted && cyc < 50) begin @(negedge clk); cyc++; end
    check("t1_cycles",   32'(cyc),           32'd9);
    check("t1_loads",    32'(load_q.size()), 32'd3);
    check("t1_load_pc0", 32'(load_q[0]),     32'd0);
    check("t1_load_pc1", 32'(load_q[1]),     32'd1);
    check("t1_load_pc2", 32'(load_q[2]),     32'd2);
    check("t1_state",    32'(state),         32'd4);
    check("t1_pc",       32'(pc),            32'd2);
    check("t1_mem_req",  32'(mem_req),       32'd0);
    check("t1_fault",    32'(fault),         32'd0);
    repeat (6) @(negedge clk);
    check("t1_sticky_state", 32'(state),           32'd4);
    check("t1_sticky_pc",    32'(pc),              32'd2);
    check("t1_sticky_loads", 32'(load_q.size()),   32'd3);

    // Jump to A, jump to F, then wrap F -> 0
    do_reset();
    fill_mem(OP_ADD);
    mem[3]  = 10'b0101_00_1010;
    mem[10] = 10'b0101_00_1111;
    run = 1'b1;
    cyc = 0;
    while (fetch_q.size() < 7 && cyc < 80) begin @(negedge clk); cyc++; end
    run = 1'b0;
    check("t2_fetch_count", 32'(fetch_q.size() >= 7), 32'd1);
    for (int i = 0; i < 7; i++) check($sformatf("t2_fetch%0d", i), 32'(fetch_q[i]), 32'(exp_fetch[i]));

    // Never ack: fault after 15 FETCH cycles, sticky
    do_reset();
    ack_en = 1'b0;
    run = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fault) break;
      if (mem_req) cnt++;
    end
    check("t4_wait_cycles", 32'(cnt),     32'd15);
    check("t4_fault",       32'(fault),   32'd1);
    check("t4_halted",      32'(halted),  32'd1);
    check("t4_mem_req",     32'(mem_req), 32'd0);
    check("t4_state",       32'(state),   32'd5);
    ack_en = 1'b1;
    repeat (5) @(negedge clk);
    check("t4_sticky_fault", 32'(fault),   32'd1);
    check("t4_sticky_state", 32'(state),   32'd5);
    check("t4_sticky_req",   32'(mem_req), 32'd0);

    // Reset asserted while waiting on the second fetch
    do_reset();
    fill_mem(OP_ADD);
    run = 1'b1;
    cyc = 0;
    while (!IRload && cyc < 10) begin @(negedge clk); cyc++; end
    ack_en = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_pre_req", 32'(mem_req), 32'd1);
    check("t5_pre_pc",  32'(pc),      32'd1);
    check("t5_pre_ir",  32'(IR),      32'(OP_ADD));
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_req",   32'(mem_req), 32'd0);
    check("t5_rst_pc",    32'(pc),      32'd0);
    check("t5_rst_ir",    32'(IR),      32'd0);
    check("t5_rst_state", 32'(state),   32'd0);
    @(negedge clk);
    fetch_q.delete();
    ack_en = 1'b1;
    rst_n = 1'b1;
    cyc = 0;
    while (fetch_q.size() < 1 && cyc < 10) begin @(negedge clk); cyc++; end
    check("t5_refetch_seen", 32'(fetch_q.size() >= 1), 32'd1);
    check("t5_refetch_addr", 32'(fetch_q[0]),          32'd0);

`ifdef SINGLE_STEP_EN
    // One instruction per step edge; a held step runs only one
    do_reset();
    fill_mem(OP_ADD);
    run = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_no_step_loads", 32'(load_q.size()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (6) @(negedge clk);
      check($sformatf("t6_idle%0d", i), 32'(state), 32'd0);
    end
    check("t6_loads", 32'(load_q.size()), 32'd3);
    step = 1'b1;
    repeat (20) @(negedge clk);
    check("t6_held_loads", 32'(load_q.size()), 32'd4);
    check("t6_held_state", 32'(state),         32'd0);
    step = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
